// File: rtl/mem_wb_stage.sv
// Memory stage: data RAM access with programmable wait states, OUT_PORT / RET
// redirect handling and the MEM/WB register feeding the register file.
module mem_wb_stage #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en_regf_M,
  input  logic       wr_en_dmem_M,
  input  logic       rd_en_M,
  input  logic       out_port_sel_M,
  input  logic       is_ret_M,
  input  logic       mux_out_sel_M,
  input  logic [1:0] mux_rdata_sel_M,
  input  logic [7:0] alu_out_M,
  input  logic [1:0] rd_M,
  input  logic [7:0] IN_PORT_M,
  input  logic [7:0] instr_M,
  input  logic [7:0] mem_addr_M,
  input  logic [7:0] mem_wd_M,
  output logic       stall_mem,
  output logic [7:0] OUT_PORT,
  output logic       pc_ret_valid,
  output logic [7:0] pc_ret,
  output logic       wr_en_regf_W,
  output logic [1:0] rd_W,
  output logic [7:0] wdata_W
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit         HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [2:0] WS_LAST  = HAS_WAIT ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg, state_next;
  logic [2:0] wcnt_reg, wcnt_next;
  logic       stall_next;
  logic       access;
  logic       complete;
  logic [AW-1:0] addr;
  logic [7:0] rdata;
  logic [7:0] wb_data;
  logic [7:0] out_data;

  logic [7:0] ram [DEPTH];

  assign access = rd_en_M | wr_en_dmem_M | is_ret_M;
  assign addr   = mem_addr_M[AW-1:0];
  assign rdata  = ram[addr];

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    stall_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (access && HAS_WAIT) begin
          stall_next = 1'b1;
          wcnt_next  = WS_LAST;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (wcnt_reg != 3'd0) begin
          stall_next = 1'b1;
          wcnt_next  = wcnt_reg - 3'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall is masked while reset is held so upstream is never frozen by a dead access.
  assign stall_mem = stall_next & reset;
  assign complete  = ~stall_next;

  always_comb begin
    case (mux_rdata_sel_M)
      2'b00:   wb_data = alu_out_M;
      2'b01:   wb_data = rdata;
      2'b10:   wb_data = IN_PORT_M;
      default: wb_data = instr_M;
    endcase
  end

  assign out_data = mux_out_sel_M ? mem_wd_M : alu_out_M;

  // Write happens only on the completion edge, so a reset mid-access drops it.
  always_ff @(posedge clk) begin
    if (reset && complete && wr_en_dmem_M) begin
      ram[addr] <= mem_wd_M;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      wcnt_reg     <= 3'd0;
      OUT_PORT     <= 8'h00;
      pc_ret_valid <= 1'b0;
      pc_ret       <= 8'h00;
      wr_en_regf_W <= 1'b0;
      rd_W         <= 2'd0;
      wdata_W      <= 8'h00;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      if (complete) begin
        wr_en_regf_W <= wr_en_regf_M;
        rd_W         <= rd_M;
        wdata_W      <= wb_data;
        pc_ret_valid <= is_ret_M;
        if (is_ret_M) begin
          pc_ret <= rdata;
        end
        if (out_port_sel_M) begin
          OUT_PORT <= out_data;
        end
      end else begin
        // Bubble: rd_W and wdata_W keep their last values.
        wr_en_regf_W <= 1'b0;
        pc_ret_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage, exercising instances with
// WAIT_STATES of 1, 3 and 2 one at a time.
module tb_mem_wb_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en_regf_M, wr_en_dmem_M, rd_en_M, out_port_sel_M, is_ret_M, mux_out_sel_M;
  logic [1:0] mux_rdata_sel_M, rd_M;
  logic [7:0] alu_out_M, IN_PORT_M, instr_M, mem_addr_M, mem_wd_M;

  logic       stall [3];
  logic [7:0] outp  [3];
  logic       pcv   [3];
  logic [7:0] pcr   [3];
  logic       wen   [3];
  logic [1:0] rdw   [3];
  logic [7:0] wdw   [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int WS = (gi == 0) ? 1 : (gi == 1) ? 3 : 2;
    mem_wb_stage #(.DEPTH(256), .WAIT_STATES(WS)) u_dut (
      .clk             (clk),
      .reset           (reset),
      .wr_en_regf_M    (wr_en_regf_M),
      .wr_en_dmem_M    (wr_en_dmem_M),
      .rd_en_M         (rd_en_M),
      .out_port_sel_M  (out_port_sel_M),
      .is_ret_M        (is_ret_M),
      .mux_out_sel_M   (mux_out_sel_M),
      .mux_rdata_sel_M (mux_rdata_sel_M),
      .alu_out_M       (alu_out_M),
      .rd_M            (rd_M),
      .IN_PORT_M       (IN_PORT_M),
      .instr_M         (instr_M),
      .mem_addr_M      (mem_addr_M),
      .mem_wd_M        (mem_wd_M),
      .stall_mem       (stall[gi]),
      .OUT_PORT        (outp[gi]),
      .pc_ret_valid    (pcv[gi]),
      .pc_ret          (pcr[gi]),
      .wr_en_regf_W    (wen[gi]),
      .rd_W            (rdw[gi]),
      .wdata_W         (wdw[gi])
    );
  end

  typedef struct packed {
    logic       wen;
    logic [1:0] rd;
    logic [7:0] wd;
    logic       pcv;
    logic [7:0] pcr;
    logic [7:0] outp;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mram [256];
  logic [7:0] m_out, m_pcr, m_wd;
  logic [1:0] m_rd;
  int         checks = 0;
  int         errors = 0;
  int         sel = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic wr_regf, input logic wr_dm, input logic rd_en,
                            input logic ops, input logic ret, input logic mos,
                            input logic [1:0] msel, input logic [7:0] alu, input logic [1:0] rd,
                            input logic [7:0] inp, input logic [7:0] ins,
                            input logic [7:0] addr, input logic [7:0] wdat);
    wr_en_regf_M = wr_regf; wr_en_dmem_M = wr_dm; rd_en_M = rd_en;
    out_port_sel_M = ops; is_ret_M = ret; mux_out_sel_M = mos;
    mux_rdata_sel_M = msel; alu_out_M = alu; rd_M = rd;
    IN_PORT_M = inp; instr_M = ins; mem_addr_M = addr; mem_wd_M = wdat;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " stall_mem"}, 8'(stall[sel]), 8'h00);
    chk({tag, " OUT_PORT"}, outp[sel], 8'h00);
    chk({tag, " pc_ret_valid"}, 8'(pcv[sel]), 8'h00);
    chk({tag, " pc_ret"}, pcr[sel], 8'h00);
    chk({tag, " wr_en_regf_W"}, 8'(wen[sel]), 8'h00);
    chk({tag, " rd_W"}, 8'(rdw[sel]), 8'h00);
    chk({tag, " wdata_W"}, wdw[sel], 8'h00);
  endtask

  task automatic do_reset(input int s);
    @(negedge clk);
    sel = s;
    reset = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_out = 8'h00; m_pcr = 8'h00; m_wd = 8'h00; m_rd = 2'd0;
  endtask

  // Drive one instruction, push its expected MEM/WB result, then follow the
  // stall until completion and compare against the popped scoreboard entry.
  task automatic issue(input logic wr_regf, input logic wr_dm, input logic rd_en,
                       input logic ops, input logic ret, input logic mos,
                       input logic [1:0] msel, input logic [7:0] alu, input logic [1:0] rd,
                       input logic [7:0] inp, input logic [7:0] ins,
                       input logic [7:0] addr, input logic [7:0] wdat,
                       input int exp_stall, input string tag);
    exp_t       e;
    exp_t       got;
    logic [7:0] o_out, o_wd;
    logic [1:0] o_rd;
    int         n;
    @(negedge clk);
    set_inputs(wr_regf, wr_dm, rd_en, ops, ret, mos, msel, alu, rd, inp, ins, addr, wdat);
    o_out = m_out; o_wd = m_wd; o_rd = m_rd;
    case (msel)
      2'b00:   e.wd = alu;
      2'b01:   e.wd = mram[addr];
      2'b10:   e.wd = inp;
      default: e.wd = ins;
    endcase
    e.wen = wr_regf;
    e.rd  = rd;
    e.pcv = ret;
    if (ret) m_pcr = mram[addr];
    if (ops) m_out = mos ? wdat : alu;
    e.pcr  = m_pcr;
    e.outp = m_out;
    if (wr_dm) mram[addr] = wdat;
    sb.push_back(e);
    #1;
    n = 0;
    while (stall[sel] === 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      chk({tag, " bubble wr_en_regf_W"}, 8'(wen[sel]), 8'h00);
      chk({tag, " bubble pc_ret_valid"}, 8'(pcv[sel]), 8'h00);
      chk({tag, " stall OUT_PORT"}, outp[sel], o_out);
      chk({tag, " stall wdata_W hold"}, wdw[sel], o_wd);
      chk({tag, " stall rd_W hold"}, 8'(rdw[sel]), 8'(o_rd));
    end
    chk({tag, " stall cycles"}, 8'(n), 8'(exp_stall));
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, " wr_en_regf_W"}, 8'(wen[sel]), 8'(got.wen));
    chk({tag, " rd_W"}, 8'(rdw[sel]), 8'(got.rd));
    chk({tag, " wdata_W"}, wdw[sel], got.wd);
    chk({tag, " pc_ret_valid"}, 8'(pcv[sel]), 8'(got.pcv));
    chk({tag, " pc_ret"}, pcr[sel], got.pcr);
    chk({tag, " OUT_PORT"}, outp[sel], got.outp);
    m_rd = got.rd;
    m_wd = got.wd;
    $display("txn %s: dut%0d stalls=%0d wdata_W=%h rd_W=%0d OUT_PORT=%h pc_ret=%h",
             tag, sel, n, wdw[sel], rdw[sel], outp[sel], pcr[sel]);
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d, input int ws);
    issue(0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, a, d, ws, "write");
  endtask

  task automatic mem_read(input logic [7:0] a, input logic [1:0] r, input int ws);
    issue(1, 0, 1, 0, 0, 0, 2'b01, 8'h00, r, 8'h00, 8'h00, a, 8'h00, ws, "read");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    set_inputs(0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);

    // WAIT_STATES = 1
    do_reset(0);
    mem_write(8'h10, 8'h5A, 1);
    mem_read(8'h10, 2'd2, 1);
    issue(1, 0, 0, 0, 0, 0, 2'b10, 8'h00, 2'd1, 8'hC3, 8'h00, 8'h00, 8'h00, 0, "in_port");
    issue(1, 0, 0, 0, 0, 0, 2'b11, 8'h00, 2'd3, 8'h00, 8'h9D, 8'h00, 8'h00, 0, "instr");
    mem_write(8'h30, 8'h11, 1);
    issue(1, 1, 1, 0, 0, 0, 2'b01, 8'h00, 2'd1, 8'h00, 8'h00, 8'h30, 8'h99, 1, "rd+wr");
    mem_read(8'h30, 2'd0, 1);
    mem_write(8'hFE, 8'h42, 1);
    issue(0, 0, 0, 0, 1, 0, 2'b00, 8'h07, 2'd0, 8'h00, 8'h00, 8'hFE, 8'h00, 1, "ret");
    issue(0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, "nop");

    // WAIT_STATES = 3
    do_reset(1);
    issue(1, 0, 0, 0, 0, 0, 2'b00, 8'h33, 2'd1, 8'h00, 8'h00, 8'h00, 8'h00, 0, "alu");
    mem_write(8'h40, 8'h6C, 3);
    mem_read(8'h40, 2'd2, 3);
    issue(0, 0, 0, 1, 0, 0, 2'b00, 8'h3C, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00, 0, "out_alu");
    issue(0, 1, 0, 1, 0, 1, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h50, 8'hA5, 3, "out_wd");

    // WAIT_STATES = 2, reset during the second stall cycle of a write
    do_reset(2);
    mem_write(8'h20, 8'h11, 2);
    @(negedge clk);
    set_inputs(0, 1, 0, 1, 0, 1, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h20, 8'h77);
    #1;
    chk("abort first stall", 8'(stall[sel]), 8'h01);
    @(posedge clk);
    #1;
    chk("abort second stall", 8'(stall[sel]), 8'h01);
    reset = 1'b0;
    #1;
    chk_zero("abort reset");
    $display("txn abort: dut%0d reset asserted mid-write", sel);
    @(negedge clk);
    set_inputs(0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    m_out = 8'h00; m_pcr = 8'h00; m_wd = 8'h00; m_rd = 2'd0;
    mem_read(8'h20, 2'd1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
